// File: rtl/wrr_sched_pkg.sv
// wrr_sched_pkg: shared types, defaults and round-robin pick function for wrr_sched
package wrr_sched_pkg;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam int DEF_WEIGHT_W = 4;
    localparam int MAX_Q = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Nearest eligible queue after last wins; last itself has the lowest priority.
    function automatic pick_t rr_pick(input logic [MAX_Q-1:0] eligible, input logic [2:0] last, input int n);
        pick_t p;
        p = '0;
        for (int k = MAX_Q; k >= 1; k--) begin
            int j;
            j = (int'(last) + k) % n;
            if (k <= n && eligible[j]) begin
                p.found = 1'b1;
                p.idx = j[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// rr_pick_comb: combinational rotate/priority-encode picking the next eligible requester after last
module rr_pick_comb
    import wrr_sched_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    pick_t p;

    always_comb p = rr_pick(MAX_Q'(eligible), 3'(last), N);

    assign found = p.found;
    assign idx = IW'(p.idx);

endmodule

// File: rtl/wrr_sched.sv
// wrr_sched: weighted round-robin scheduler driving a one-hot egress mux select.
// Optional per-queue starvation monitor enabled by defining WRR_STARVE_MON_EN.
module wrr_sched
    import wrr_sched_pkg::*;
#(
    parameter int NUM_Q = 3,
    parameter int WEIGHT_W = DEF_WEIGHT_W
`ifdef WRR_STARVE_MON_EN
    , parameter int STARVE_LIMIT = 64
`endif
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_Q-1:0]          q_rdy,
    input  logic [NUM_Q*WEIGHT_W-1:0] q_weight,
    input  logic                      unit_done,
    output logic [NUM_Q-1:0]          sel,
    output logic                      sel_vld,
    output logic [WEIGHT_W-1:0]       credit
`ifdef WRR_STARVE_MON_EN
    , output logic [NUM_Q-1:0]        q_starve
`endif
);

    localparam int IW = $clog2(NUM_Q);

    state_t              state, state_d;
    logic [NUM_Q-1:0]    elig, sel_d;
    logic [WEIGHT_W-1:0] credit_d;
    logic [WEIGHT_W-1:0] w [NUM_Q];
    logic [IW-1:0]       last, last_d, win;
    logic                found, rel;

    for (genvar i = 0; i < NUM_Q; i++) begin : g_q
        assign w[i] = q_weight[i*WEIGHT_W +: WEIGHT_W];
        assign elig[i] = q_rdy[i] && w[i] != '0;
    end

    rr_pick_comb #(.N(NUM_Q)) u_pick (
        .eligible(elig),
        .last(last),
        .found(found),
        .idx(win)
    );

    // While granted, last is the current queue.
    assign rel = state == ST_GRANT && ((unit_done && credit == WEIGHT_W'(1)) || !q_rdy[last]);

    always_comb begin
        state_d = state;
        sel_d = sel;
        credit_d = credit;
        last_d = last;
        if (state == ST_IDLE || rel) begin
            state_d = found ? ST_GRANT : ST_IDLE;
            sel_d = found ? NUM_Q'(1) << win : '0;
            credit_d = found ? w[win] : '0;
            last_d = found ? win : last;
        end else if (unit_done) begin
            credit_d = credit - WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel <= '0;
            sel_vld <= 1'b0;
            credit <= '0;
            last <= IW'(NUM_Q - 1);
        end else begin
            state <= state_d;
            sel <= sel_d;
            sel_vld <= |sel_d;
            credit <= credit_d;
            last <= last_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(sel_vld && credit == '0));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel) && sel_vld == |sel);

`ifdef WRR_STARVE_MON_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] wait_cnt [NUM_Q];

    // A grant clears the count on the edge it is issued.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_Q; i++) begin
            if (!rst_n || !elig[i] || sel_d[i])
                wait_cnt[i] <= '0;
            else if (!sel[i] && wait_cnt[i] != CW'(STARVE_LIMIT))
                wait_cnt[i] <= wait_cnt[i] + CW'(1);
            q_starve[i] <= rst_n && wait_cnt[i] == CW'(STARVE_LIMIT);
        end
    end
`endif

endmodule

// File: tb/tb_wrr_sched.sv
// tb_wrr_sched: scoreboard bench for wrr_sched; expected {sel_vld, sel, credit} per cycle is queued then compared.
module tb_wrr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  q_rdy;
    logic [11:0] q_weight;
    logic        unit_done;
    logic [2:0]  sel;
    logic        sel_vld;
    logic [3:0]  credit;
    logic [7:0]  obs;
    logic [7:0]  e;
    logic [7:0]  sb [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

`ifdef WRR_STARVE_MON_EN
    logic [2:0] q_starve;
    logic       sq [$];
    logic       se;

    wrr_sched #(.NUM_Q(3), .WEIGHT_W(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .q_rdy(q_rdy), .q_weight(q_weight), .unit_done(unit_done),
        .sel(sel), .sel_vld(sel_vld), .credit(credit), .q_starve(q_starve)
    );
`else
    wrr_sched #(.NUM_Q(3), .WEIGHT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .q_rdy(q_rdy), .q_weight(q_weight), .unit_done(unit_done),
        .sel(sel), .sel_vld(sel_vld), .credit(credit)
    );
`endif

    assign obs = {sel_vld, sel, credit};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [2:0] s, input logic [3:0] c);
        sb.push_back({v, s, c});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q_rdy = '0;
        unit_done = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q_rdy = '1;
        q_weight = {4'd1, 4'd2, 4'd3};
        unit_done = 1'b1;
        repeat (3) push(0, 3'b000, 0);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL reset: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_weighted();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd3};
        q_rdy = 3'b111;
        unit_done = 1'b1;
        repeat (2) begin
            push(1, 3'b001, 3); push(1, 3'b001, 2); push(1, 3'b001, 1);
            push(1, 3'b010, 2); push(1, 3'b010, 1);
            push(1, 3'b100, 1);
        end
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL weighted: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_single();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd3};
        q_rdy = 3'b010;
        unit_done = 1'b1;
        repeat (4) begin push(1, 3'b010, 2); push(1, 3'b010, 1); end
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL single: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_drop();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd3};
        q_rdy = 3'b011;
        unit_done = 1'b1;
        push(1, 3'b001, 3); push(1, 3'b001, 2);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL drop_switch: got %h want %h", obs, e); end
        end
        q_rdy = 3'b010;
        push(1, 3'b010, 2);
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL drop_switch: got %h want %h", obs, e); end
        unit_done = 1'b0;
        push(1, 3'b010, 2); push(1, 3'b010, 2);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL hold_no_done: got %h want %h", obs, e); end
        end
        unit_done = 1'b1;
        push(1, 3'b010, 1); push(1, 3'b010, 2);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL drop_resume: got %h want %h", obs, e); end
        end
        apply_reset();
        q_rdy = 3'b001;
        unit_done = 1'b1;
        push(1, 3'b001, 3); push(1, 3'b001, 2);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL drop_idle: got %h want %h", obs, e); end
        end
        q_rdy = 3'b000;
        push(0, 3'b000, 0); push(0, 3'b000, 0);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL drop_idle: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_zero_weight();
        apply_reset();
        q_weight = {4'd0, 4'd2, 4'd3};
        q_rdy = 3'b111;
        unit_done = 1'b1;
        repeat (2) begin
            push(1, 3'b001, 3); push(1, 3'b001, 2); push(1, 3'b001, 1);
            push(1, 3'b010, 2); push(1, 3'b010, 1);
        end
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL zero_weight: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd3};
        q_rdy = 3'b001;
        unit_done = 1'b1;
        push(1, 3'b001, 3); push(1, 3'b001, 2);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL mid_reset: got %h want %h", obs, e); end
        end
        rst_n = 1'b0;
        push(0, 3'b000, 0);
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL mid_reset: got %h want %h", obs, e); end
        rst_n = 1'b1;
        q_rdy = 3'b111;
        push(1, 3'b001, 3);
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_first_win: got %h want %h", obs, e); end
    endtask

    task automatic test_weight_sample();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd3};
        q_rdy = 3'b001;
        unit_done = 1'b1;
        push(1, 3'b001, 3);
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL weight_sample: got %h want %h", obs, e); end
        q_weight[3:0] = 4'd5;
        push(1, 3'b001, 2); push(1, 3'b001, 1); push(1, 3'b001, 5); push(1, 3'b001, 4);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL weight_sample: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_max_weight();
        apply_reset();
        q_weight = {4'd1, 4'd2, 4'd15};
        q_rdy = 3'b001;
        unit_done = 1'b0;
        repeat (3) push(1, 3'b001, 15);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL max_weight: got %h want %h", obs, e); end
        end
        unit_done = 1'b1;
        push(1, 3'b001, 14);
        tick();
        e = sb.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL max_weight: got %h want %h", obs, e); end
    endtask

`ifdef WRR_STARVE_MON_EN
    task automatic test_starve();
        apply_reset();
        q_weight = {4'd1, 4'd1, 4'd15};
        q_rdy = 3'b011;
        unit_done = 1'b1;
        for (int k = 1; k <= 17; k++) sq.push_back(k >= 5 && k <= 16);
        while (sq.size() > 0) begin
            tick();
            se = sq.pop_front();
            total++;
            if (q_starve[1] !== se) begin bad++; $display("FAIL starve: got %b want %b", q_starve[1], se); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_weighted();
        test_single();
        test_drop();
        test_zero_weight();
        test_mid_reset();
        test_weight_sample();
        test_max_weight();
`ifdef WRR_STARVE_MON_EN
        test_starve();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrr_sched.md
Name: wrr_sched

Overview:
- Weighted round-robin scheduler that shares one downstream datapath (the egress mux) between NUM_Q ready queues.
- Each grant is held for up to WEIGHT[i] consumed units, or until the queue drops ready, then passes to the next eligible queue in circular order.
- Sits between the per-queue ready flags and the egress mux select. Upgrade path for plain 1-unit round-robin scheduling where queues need unequal bandwidth shares.

Parameters:
- NUM_Q, 3, number of requesting queues (2..8).
- WEIGHT_W, 4, bits per queue weight. Max burst is 2^WEIGHT_W-1 units.
- STARVE_LIMIT, 64, cycles a ready, nonzero-weight queue may wait ungranted before its starve flag sets (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- q_rdy  in  NUM_Q  per-queue "has data" level.
- q_weight  in  NUM_Q*WEIGHT_W  packed weights; queue i at [i*WEIGHT_W +: WEIGHT_W].
- unit_done  in  1  downstream consumed one unit from the selected queue this cycle. Ignored when sel_vld=0.
- sel  out  NUM_Q  one-hot grant, registered; all-zero when idle.
- sel_vld  out  1  registered; high when sel is nonzero.
- credit  out  WEIGHT_W  remaining units in the current burst; 0 when idle.

Behaviour:
- Reset (rst_n=0 at edge): sel=0, sel_vld=0, credit=0, state=IDLE, last pointer=NUM_Q-1 (queue 0 wins first). Takes effect from any state mid-burst.
- Eligible queue: q_rdy[i]=1 and weight[i]!=0. Weight-0 queues are never granted.
- Arbitration: search starts at (last+1) mod NUM_Q and wraps. The current queue may win again only if no other queue is eligible.
- FSM, two states:
  - IDLE: if any queue is eligible, at next edge sel=onehot(winner), sel_vld=1, credit=weight[winner], last=winner, go to GRANT. Otherwise stay.
  - GRANT, release condition: (unit_done and credit==1) or q_rdy[cur]==0.
  - GRANT, no release: if unit_done, credit decrements by 1; sel is held.
  - GRANT, release: re-arbitrate in the same cycle. Winner present -> switch directly to it next edge, no idle bubble, credit reloaded. No winner -> next edge sel=0, sel_vld=0, credit=0, go to IDLE.
- Latency: ready to sel_vld is 1 cycle. Last done to new sel is 1 cycle.
- unit_done and q_rdy[cur] falling together: release. The done is counted but has no further effect.
- Weights are sampled only at grant time. A mid-burst weight change applies from that queue's next grant.
- Credit never underflows. credit==0 with sel_vld=1 is unreachable; assert on it.
- sel is always one-hot or zero. sel_vld == |sel.

Optional Feature:
- Macro WRR_STARVE_MON_EN.
- Defined:
  - Adds output q_starve[NUM_Q] and a per-queue wait counter, saturating at STARVE_LIMIT.
  - Counter increments each cycle the queue is eligible and not selected. It clears when the queue is granted, goes ineligible, or reset.
  - q_starve[i] is registered and high while counter[i]==STARVE_LIMIT.
- Undefined: port and counters are absent; scheduling is identical.

Decomposition:
- Package wrr_sched_pkg holds:
  - FSM state enum (ST_IDLE, ST_GRANT).
  - Default WEIGHT_W.
  - Function rr_pick(eligible, last) returning winner index plus found bit.
- One sub-module, rr_pick_comb: pure combinational rotate/priority-encode, reusable by other arbiters.
- FSM, credit counter and optional starve counters stay in wrr_sched.

Test Plan:
- Weights {q2,q1,q0}={1,2,3}, all ready, unit_done=1 every cycle -> sel sequence 001×3, 010×2, 100×1, repeating. sel_vld held high, no bubble.
- Only q1 ready, weight 2, done every cycle -> sel=010 continuously. credit sequence 2,1,2,1.
- q0 granted, weight 3, q0_rdy drops after 1 done -> switch to next eligible next cycle. If none eligible, sel=0, sel_vld=0, credit=0.
- q2 weight 0, all ready -> q2 never selected. Rotation is q0,q1 only.
- rst_n low for 1 cycle mid-burst with credit=2 -> next edge sel=0, credit=0. After release, q0 wins first.
- WRR_STARVE_MON_EN, STARVE_LIMIT=4, q0 weight 15 with done every cycle, q1 ready -> q_starve[1] rises 5 cycles after q1 becomes ready, clears the cycle after q1 is granted.
